core_msg_router: RTL and testbench

//  Inter-core instruction router, successor to the single-beat bus. N cores send (src, instr) messages under

---
 rtl/core_msg_router_if.sv | 33 +++
 rtl/core_msg_router.sv | 181 ++++++++++++++++++
 tb/tb_core_msg_router.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_msg_router_if.sv
// core_msg_router_if: send/receive bundle between the cores and the message router.
//   master : core side  (drives send_valid, dst_mask, instructions, recv_ready)
//   slave  : router side (drives send_ready, recv_valid, recv_src_id, recv_instr,
//                         fifo_level, drop_err)
// All buses are flat: slice i of a multi-core bus belongs to core i.
interface core_msg_router_if #(
   parameter int NUM_CORES   = 4,
   parameter int INSTR_WIDTH = 2,
   parameter int FIFO_DEPTH  = 4
);
   localparam int CORE_ID_WIDTH = $clog2(NUM_CORES);
   localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_CORES-1:0]               send_valid;
   logic [NUM_CORES*NUM_CORES-1:0]     dst_mask;
   logic [NUM_CORES*INSTR_WIDTH-1:0]   instructions;
   logic [NUM_CORES-1:0]               send_ready;
   logic [NUM_CORES-1:0]               recv_valid;
   logic [NUM_CORES-1:0]               recv_ready;
   logic [NUM_CORES*CORE_ID_WIDTH-1:0] recv_src_id;
   logic [NUM_CORES*INSTR_WIDTH-1:0]   recv_instr;
   logic [NUM_CORES*LVL_W-1:0]         fifo_level;
   logic                               drop_err;

   modport master (
      output send_valid, dst_mask, instructions, recv_ready,
      input  send_ready, recv_valid, recv_src_id, recv_instr, fifo_level, drop_err
   );
   modport slave (
      input  send_valid, dst_mask, instructions, recv_ready,
      output send_ready, recv_valid, recv_src_id, recv_instr, fifo_level, drop_err
   );
endinterface

// File: rtl/core_msg_router.sv
// core_msg_router: N-core multicast instruction router.
//   clk, reset : clock, synchronous active-high reset (flushes all queues)
//   bus        : core_msg_router_if.slave
//     send_*   : per-core offer {dst_mask, instruction}, one-hot round-robin grant
//     recv_*   : per-destination receive FIFO head, pop handshake, occupancy
//     drop_err : sticky, set when a message with no destination other than its
//                sender is accepted
// Contains the per-destination FIFO lane (core_msg_router_fifo), instantiated
// as an instance array, and the top-level arbiter.

// One receive FIFO lane. push is only asserted when the lane has room; the
// guard below keeps the lane self-consistent regardless.
module core_msg_router_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic             pop_req,
   output logic             valid,
   output logic [DW-1:0]    head,
   output logic [LVL_W-1:0] level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0]         lvl_q, lvl_d;
   logic                     do_push, do_pop;

   always_comb begin
      do_pop  = pop_req & (lvl_q != '0);
      do_push = push & (lvl_q != LVL_W'(DEPTH));
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      lvl_d   = lvl_q;
      // DEPTH is a power of two, so pointer increments wrap naturally
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   lvl_d = lvl_q + 1'b1;
         2'b01:   lvl_d = lvl_q - 1'b1;
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   assign valid = (lvl_q != '0);
   assign head  = mem_q[rd_q];
   assign level = lvl_q;
endmodule

module core_msg_router #(
   parameter int NUM_CORES   = 4,
   parameter int INSTR_WIDTH = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   core_msg_router_if.slave  bus
);
   localparam int CORE_ID_WIDTH = $clog2(NUM_CORES);
   localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;
   localparam int MSG_W         = CORE_ID_WIDTH + INSTR_WIDTH;

   logic [NUM_CORES-1:0][NUM_CORES-1:0] eff;
   logic [NUM_CORES-1:0]                full, elig, push, pop_req, lane_vld;
   logic [NUM_CORES-1:0][MSG_W-1:0]     head, push_data;
   logic [NUM_CORES-1:0][LVL_W-1:0]     lvl;
   logic [CORE_ID_WIDTH-1:0]            ptr_q, ptr_d, gnt_idx;
   logic                                gnt_found, drop_err_q, drop_err_d;
   int                                  cand;

   // Effective destinations and eligibility. Fullness uses the registered
   // level, so a pop in this cycle does not open space for this cycle's grant.
   always_comb begin
      eff  = '0;
      full = '0;
      elig = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         eff[i]    = bus.dst_mask[i*NUM_CORES +: NUM_CORES];
         eff[i][i] = 1'b0;
         full[i]   = (lvl[i] == LVL_W'(FIFO_DEPTH));
      end
      for (int i = 0; i < NUM_CORES; i++)
         elig[i] = bus.send_valid[i] & ~|(eff[i] & full);
   end

   // Round-robin: first eligible core at or after ptr_q, wrapping
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int off = 0; off < NUM_CORES; off++) begin
         cand = (int'(ptr_q) + off) % NUM_CORES;
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = CORE_ID_WIDTH'(cand);
         end
      end
      if (reset) gnt_found = 1'b0;
   end

   // Grant, multicast write and pointer/error update
   always_comb begin
      bus.send_ready = '0;
      push           = '0;
      ptr_d          = ptr_q;
      drop_err_d     = drop_err_q;
      for (int j = 0; j < NUM_CORES; j++)
         push_data[j] = {gnt_idx, bus.instructions[gnt_idx*INSTR_WIDTH +: INSTR_WIDTH]};
      if (gnt_found) begin
         bus.send_ready[gnt_idx] = 1'b1;
         push                    = eff[gnt_idx];
         ptr_d = (gnt_idx == CORE_ID_WIDTH'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
         // accepted but addressed to nobody else
         if (eff[gnt_idx] == '0) drop_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         drop_err_q <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign pop_req = bus.recv_ready;

   core_msg_router_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (MSG_W),
      .LVL_W (LVL_W)
   ) u_fifo [NUM_CORES-1:0] (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop_req   (pop_req),
      .valid     (lane_vld),
      .head      (head),
      .level     (lvl)
   );

   always_comb begin
      bus.recv_valid  = lane_vld;
      bus.recv_src_id = '0;
      bus.recv_instr  = '0;
      bus.fifo_level  = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         bus.recv_src_id[j*CORE_ID_WIDTH +: CORE_ID_WIDTH] = head[j][MSG_W-1 -: CORE_ID_WIDTH];
         bus.recv_instr[j*INSTR_WIDTH +: INSTR_WIDTH]      = head[j][INSTR_WIDTH-1:0];
         bus.fifo_level[j*LVL_W +: LVL_W]                  = lvl[j];
      end
   end

   assign bus.drop_err = drop_err_q;
endmodule

// File: tb/tb_core_msg_router.sv
module tb_core_msg_router;
   localparam int N  = 4;
   localparam int W  = 2;
   localparam int D  = 4;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   core_msg_router_if #(.NUM_CORES(N), .INSTR_WIDTH(W), .FIFO_DEPTH(D)) bus ();
   core_msg_router #(.NUM_CORES(N), .INSTR_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one array-backed queue of messages per destination
   typedef struct packed {logic [1:0] src; logic [1:0] ins;} msg_t;
   msg_t mbuf [N][D];
   int   mcnt [N];
   int   mptr;
   logic mdrop;
   int   mgnt;

   typedef struct {
      logic        rst;
      logic [3:0]  sv;
      logic [15:0] dm;
      logic [7:0]  ins;
      logic [3:0]  rr;
      logic [3:0]  exp_sr;
      logic [3:0]  exp_rv;
      logic        exp_drop;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic int model_grant(input logic rst, input logic [N-1:0] sv, input logic [N*N-1:0] dm);
      int i;
      bit ok;
      if (rst) return -1;
      for (int off = 0; off < N; off++) begin
         i = (mptr + off) % N;
         if (sv[i]) begin
            ok = 1'b1;
            for (int j = 0; j < N; j++)
               if (j != i && dm[i*N+j] && mcnt[j] == D) ok = 1'b0;
            if (ok) return i;
         end
      end
      return -1;
   endfunction

   // Drive one cycle's inputs, compare every output to the model, then advance
   // the model to the state after the coming edge. Caller waits for the edge.
   task automatic apply(input logic rst, input logic [N-1:0] sv, input logic [N*N-1:0] dm,
                        input logic [N*W-1:0] ins, input logic [N-1:0] rr);
      int   g;
      bit   any;
      msg_t m;
      reset            = rst;
      bus.send_valid   = sv;
      bus.dst_mask     = dm;
      bus.instructions = ins;
      bus.recv_ready   = rr;
      #1;
      g = model_grant(rst, sv, dm);
      chk("send_ready", 32'(bus.send_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
      chk("drop_err", 32'(bus.drop_err), 32'(mdrop));
      for (int j = 0; j < N; j++) begin
         chk($sformatf("fifo_level[%0d]", j), 32'(bus.fifo_level[j*LW +: LW]), 32'(mcnt[j]));
         chk($sformatf("recv_valid[%0d]", j), 32'(bus.recv_valid[j]), 32'(mcnt[j] > 0));
         if (mcnt[j] > 0) begin
            chk($sformatf("recv_src_id[%0d]", j), 32'(bus.recv_src_id[j*2 +: 2]), 32'(mbuf[j][0].src));
            chk($sformatf("recv_instr[%0d]", j), 32'(bus.recv_instr[j*W +: W]), 32'(mbuf[j][0].ins));
         end
      end
      mgnt = g;
      if (rst) begin
         for (int j = 0; j < N; j++) mcnt[j] = 0;
         mptr  = 0;
         mdrop = 1'b0;
      end else begin
         for (int j = 0; j < N; j++)
            if (rr[j] && mcnt[j] > 0) begin
               for (int k = 0; k < D-1; k++) mbuf[j][k] = mbuf[j][k+1];
               mcnt[j]--;
            end
         if (g >= 0) begin
            any   = 1'b0;
            m.src = g[1:0];
            m.ins = ins[g*W +: W];
            for (int j = 0; j < N; j++)
               if (j != g && dm[g*N+j]) begin
                  mbuf[j][mcnt[j]] = m;
                  mcnt[j]++;
                  any = 1'b1;
               end
            if (!any) mdrop = 1'b1;
            mptr = (g + 1) % N;
         end
      end
   endtask

   task automatic step(input logic rst, input logic [N-1:0] sv, input logic [N*N-1:0] dm,
                       input logic [N*W-1:0] ins, input logic [N-1:0] rr);
      apply(rst, sv, dm, ins, rr);
      @(negedge clk);
   endtask

   logic [3:0]  rsv;
   logic [15:0] rdm;
   logic [7:0]  rins;
   logic [3:0]  rrr;

   initial begin
      for (int j = 0; j < N; j++) mcnt[j] = 0;
      mptr  = 0;
      mdrop = 1'b0;
      mgnt  = -1;
      reset = 1'b1;
      bus.send_valid   = '1;
      bus.dst_mask     = '0;
      bus.instructions = '0;
      bus.recv_ready   = '0;
      @(negedge clk);

      //          rst   sv       dm        ins    rr       sr       rv       drop
      tbl[0]  = '{1'b1, 4'b1111, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{1'b1, 4'b1111, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      // core0 -> core2, CONTINUE; visible next cycle, popped there
      tbl[2]  = '{1'b0, 4'b0001, 16'h0004, 8'h02, 4'b0000, 4'b0001, 4'b0000, 1'b0};
      tbl[3]  = '{1'b0, 4'b0000, 16'h0000, 8'h00, 4'b0100, 4'b0000, 4'b0100, 1'b0};
      // everyone -> core3; core3's own offer is empty and gets dropped
      tbl[4]  = '{1'b1, 4'b0000, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[5]  = '{1'b0, 4'b1111, 16'h8888, 8'hE4, 4'b0000, 4'b0001, 4'b0000, 1'b0};
      tbl[6]  = '{1'b0, 4'b1111, 16'h8888, 8'hE4, 4'b0000, 4'b0010, 4'b1000, 1'b0};
      tbl[7]  = '{1'b0, 4'b1111, 16'h8888, 8'hE4, 4'b0000, 4'b0100, 4'b1000, 1'b0};
      tbl[8]  = '{1'b0, 4'b1111, 16'h8888, 8'hE4, 4'b0000, 4'b1000, 4'b1000, 1'b0};
      tbl[9]  = '{1'b0, 4'b1111, 16'h8888, 8'hE4, 4'b0000, 4'b0001, 4'b1000, 1'b1};
      tbl[10] = '{1'b0, 4'b0111, 16'h8888, 8'hE4, 4'b0000, 4'b0000, 4'b1000, 1'b1};
      // core1 broadcasts STOP; only 0, 2, 3 receive it
      tbl[11] = '{1'b1, 4'b0000, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b1000, 1'b1};
      tbl[12] = '{1'b0, 4'b0010, 16'h00F0, 8'h04, 4'b0000, 4'b0010, 4'b0000, 1'b0};
      tbl[13] = '{1'b0, 4'b0000, 16'h0000, 8'h00, 4'b0000, 4'b0000, 4'b1101, 1'b0};

      for (int r = 0; r < 14; r++) begin
         apply(tbl[r].rst, tbl[r].sv, tbl[r].dm, tbl[r].ins, tbl[r].rr);
         chk($sformatf("tbl%0d send_ready", r), 32'(bus.send_ready), 32'(tbl[r].exp_sr));
         chk($sformatf("tbl%0d recv_valid", r), 32'(bus.recv_valid), 32'(tbl[r].exp_rv));
         chk($sformatf("tbl%0d drop_err", r), 32'(bus.drop_err), 32'(tbl[r].exp_drop));
         @(negedge clk);
      end
      chk("bcast src0", 32'(bus.recv_src_id[1:0]), 32'd1);
      chk("bcast ins3", 32'(bus.recv_instr[7:6]), 32'd1);

      // FIFO3 full: core1 (needs 3) waits, core0 (only 2) passes
      step(1'b1, 4'b0000, 16'h0000, 8'h00, 4'b0000);
      for (int k = 0; k < 4; k++) step(1'b0, 4'b0001, 16'h0008, 8'h00, 4'b0000);
      apply(1'b0, 4'b0011, 16'h00C4, 8'h06, 4'b0000);
      chk("s5 core0 first", 32'(bus.send_ready), 32'b0001);
      @(negedge clk);
      apply(1'b0, 4'b0010, 16'h00C4, 8'h06, 4'b1000);
      chk("s5 pop no same-cycle space", 32'(bus.send_ready), 32'b0000);
      @(negedge clk);
      apply(1'b0, 4'b0010, 16'h00C4, 8'h06, 4'b0000);
      chk("s5 core1 after pop", 32'(bus.send_ready), 32'b0010);
      @(negedge clk);
      apply(1'b0, 4'b0000, 16'h0000, 8'h00, 4'b0000);
      chk("s5 level2", 32'(bus.fifo_level[2*LW +: LW]), 32'd2);
      chk("s5 level3", 32'(bus.fifo_level[3*LW +: LW]), 32'd4);
      @(negedge clk);

      // reset flushes a partly filled FIFO0; next unicast has 1-cycle latency
      step(1'b1, 4'b0000, 16'h0000, 8'h00, 4'b0000);
      for (int k = 0; k < 3; k++) step(1'b0, 4'b0010, 16'h0010, 8'h0C, 4'b0000);
      apply(1'b1, 4'b0000, 16'h0000, 8'h00, 4'b0000);
      chk("s6 level0 before reset", 32'(bus.fifo_level[LW-1:0]), 32'd3);
      @(negedge clk);
      apply(1'b0, 4'b0100, 16'h0100, 8'h20, 4'b0000);
      chk("s6 flushed valid", 32'(bus.recv_valid), 32'd0);
      chk("s6 flushed level0", 32'(bus.fifo_level[LW-1:0]), 32'd0);
      @(negedge clk);
      apply(1'b0, 4'b0000, 16'h0000, 8'h00, 4'b0000);
      chk("s6 latency valid0", 32'(bus.recv_valid[0]), 32'd1);
      chk("s6 latency src0", 32'(bus.recv_src_id[1:0]), 32'd2);
      @(negedge clk);

      // Random traffic; offers are held until granted or withdrawn
      rsv = '0; rdm = '0; rins = '0;
      mgnt = -1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rsv[i] && mgnt == i) rsv[i] = 1'b0;
            else if (rsv[i] && $urandom_range(15) == 0) rsv[i] = 1'b0;
            else if (!rsv[i] && $urandom_range(1) == 1) begin
               rsv[i]           = 1'b1;
               rdm[i*N +: N]    = 4'($urandom());
               rins[i*W +: W]   = 2'($urandom());
            end
         end
         for (int j = 0; j < N; j++) rrr[j] = ($urandom_range(2) == 0);
         step(($urandom_range(199) == 0), rsv, rdm, rins, rrr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
